// File: rtl/cordic_angle_encoder_pkg.sv
// Shared constants, rotation-word layout and arctangent table for the CORDIC angle encoder.
package cordic_angle_encoder_pkg;

  localparam int unsigned ANGLE_W    = 16;
  localparam int unsigned LOW_W      = 13;
  localparam int unsigned REDUCED_W  = LOW_W + 1;
  localparam int unsigned OCTANT_SPAN = 8192;
  localparam int unsigned Z_W        = 20;
  localparam int unsigned STEP_W     = 5;
  localparam int unsigned SHIFT_W    = 4;
  localparam int unsigned REC_W      = 4;
  localparam int unsigned WORD_W     = 11;
  localparam int unsigned ATAN_N     = 16;

  // Rotation-word field positions.
  localparam int unsigned SHIFT_LSB  = 0;
  localparam int unsigned SIGNZ_BIT  = 4;
  localparam int unsigned LAST_BIT   = 5;
  localparam int unsigned NOROT_BIT  = 6;
  localparam int unsigned REC_LSB    = 7;

  localparam int unsigned STATE_W = 1;
  localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
  localparam logic [STATE_W-1:0] ST_EMIT = 1'b1;

  // One FIFO rotation word, MSB first: recovery[10:7], no_rotation[6], last[5], signz[4], shift[3:0].
  typedef struct packed {
    logic [REC_W-1:0]   recovery;
    logic               no_rotation;
    logic               last;
    logic               signz;
    logic [SHIFT_W-1:0] shift;
  } rot_word_t;

  // round(atan(2^-i) / (2*pi) * 2^20)
  function automatic logic [Z_W-1:0] atan_lut(input logic [SHIFT_W-1:0] idx);
    logic [Z_W-1:0] val;
    case (idx)
      4'd0:    val = 20'd131072;
      4'd1:    val = 20'd77376;
      4'd2:    val = 20'd40884;
      4'd3:    val = 20'd20753;
      4'd4:    val = 20'd10417;
      4'd5:    val = 20'd5213;
      4'd6:    val = 20'd2607;
      4'd7:    val = 20'd1304;
      4'd8:    val = 20'd652;
      4'd9:    val = 20'd326;
      4'd10:   val = 20'd163;
      4'd11:   val = 20'd81;
      4'd12:   val = 20'd41;
      4'd13:   val = 20'd20;
      4'd14:   val = 20'd10;
      default: val = 20'd5;
    endcase
    return val;
  endfunction

  function automatic logic [Z_W-1:0] abs_z(input logic [Z_W-1:0] v);
    return v[Z_W-1] ? (~v + Z_W'(1)) : v;
  endfunction

endpackage

// File: rtl/cordic_angle_encoder_select.sv
// Nearest-arctangent selector: picks the table entry closest to |z| and applies that rotation.
module cordic_angle_encoder_select
  import cordic_angle_encoder_pkg::*;
(
  input  logic [Z_W-1:0]     z,
  output logic [SHIFT_W-1:0] shift,
  output logic               signz,
  output logic [Z_W-1:0]     z_next
);

  logic [Z_W-1:0] mag;
  logic [Z_W-1:0] cand;
  logic [Z_W-1:0] diff;
  logic [Z_W-1:0] best_diff;
  logic [Z_W-1:0] sel_atan;

  // Strict less-than keeps the smaller index on a tie.
  always_comb begin
    mag       = abs_z(z);
    shift     = '0;
    best_diff = '1;
    cand      = '0;
    diff      = '0;
    for (int unsigned i = 0; i < ATAN_N; i++) begin
      cand = atan_lut(SHIFT_W'(i));
      diff = (mag >= cand) ? (mag - cand) : (cand - mag);
      if (diff < best_diff) begin
        best_diff = diff;
        shift     = SHIFT_W'(i);
      end
    end
  end

  assign sel_atan = atan_lut(shift);
  assign signz    = z[Z_W-1];
  assign z_next   = z[Z_W-1] ? (z + sel_atan) : (z - sel_atan);

endmodule

// File: rtl/cordic_angle_encoder.sv
// Reduces an angle to the first octant and streams its greedy rotation decomposition into a FIFO.
module cordic_angle_encoder
  import cordic_angle_encoder_pkg::*;
#(
  parameter int unsigned MAX_ROT = 8,
  parameter int unsigned THRESH  = 5
)
(
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic [ANGLE_W-1:0] iAngle,
  input  logic               iAngle_valid,
  output logic               oAngle_ready,
  input  logic               iFifo_full,
  output logic               oFifo_wrreq,
  output logic [WORD_W-1:0]  oFifo_data,
  output logic               oBusy
);

  logic [STATE_W-1:0]   state, state_d;
  logic [Z_W-1:0]       z, z_d;
  logic [STEP_W-1:0]    step, step_d;
  logic [REC_W-1:0]     recovery, recovery_d;

  logic [LOW_W-1:0]     low13;
  logic [REDUCED_W-1:0] reduced;
  logic [Z_W-1:0]       z_init;
  logic [Z_W-1:0]       z_mag;
  logic [Z_W-1:0]       z_next;
  logic [Z_W-1:0]       z_next_mag;
  logic [SHIFT_W-1:0]   shift;
  logic                 signz;
  logic                 last;
  logic                 no_rotation;
  logic                 wrreq;
  logic                 ready;
  logic                 busy;
  rot_word_t            word;

  // Odd octants are mirrored so the residual is always measured from the nearer axis.
  assign low13   = iAngle[LOW_W-1:0];
  assign reduced = iAngle[LOW_W] ? (REDUCED_W'(OCTANT_SPAN) - {1'b0, low13}) : {1'b0, low13};
  assign z_init  = Z_W'({reduced, 4'h0});

  cordic_angle_encoder_select u_select (
    .z      (z),
    .shift  (shift),
    .signz  (signz),
    .z_next (z_next)
  );

  assign z_mag       = abs_z(z);
  assign z_next_mag  = abs_z(z_next);
  assign last        = (z_next_mag <= Z_W'(THRESH)) || (step == STEP_W'(MAX_ROT - 1));
  assign no_rotation = (step == '0) && (z_mag <= Z_W'(THRESH));

  // Word assembly from registered state only, so it holds steady while the FIFO is full.
  always_comb begin
    word          = '0;
    word.recovery = recovery;
    if (no_rotation) begin
      word.no_rotation = 1'b1;
      word.last        = 1'b1;
    end else begin
      word.last  = last;
      word.signz = signz;
      word.shift = shift;
    end
  end

  // Next-state and strobe logic.
  always_comb begin
    state_d    = state;
    z_d        = z;
    step_d     = step;
    recovery_d = recovery;
    wrreq      = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (iAngle_valid) begin
          z_d        = z_init;
          recovery_d = {1'b0, iAngle[ANGLE_W-1:LOW_W]};
          step_d     = '0;
          state_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        busy  = 1'b1;
        wrreq = ~iFifo_full;
        if (wrreq) begin
          z_d    = z_next;
          step_d = step + STEP_W'(1);
          if (word.last || word.no_rotation) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= ST_IDLE;
      z        <= '0;
      step     <= '0;
      recovery <= '0;
    end else begin
      state    <= state_d;
      z        <= z_d;
      step     <= step_d;
      recovery <= recovery_d;
    end
  end

  assign oAngle_ready = ready;
  assign oBusy        = busy;
  assign oFifo_wrreq  = wrreq;
  assign oFifo_data   = word;

endmodule
